// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing a dual-port BRAM among NUM_REQ requesters.
// Hazard-safe same-address pairing, pipelined read return per port.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata,
  output logic                          readEnable_1,
  output logic                          writeEnable_1,
  output logic [ADDR_WIDTH-1:0]         address_1,
  output logic [DATA_WIDTH-1:0]         writeData_1,
  input  logic [DATA_WIDTH-1:0]         readData_1,
  output logic                          readEnable_2,
  output logic                          writeEnable_2,
  output logic [ADDR_WIDTH-1:0]         address_2,
  output logic [DATA_WIDTH-1:0]         writeData_2,
  input  logic [DATA_WIDTH-1:0]         readData_2,
  output logic [15:0]                   conflict_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [IW-1:0] wrap(input int v);
    wrap = IW'(v % NUM_REQ);
  endfunction

  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         a_idx, b_idx, last_idx;
  logic                  a_found, b_found;
  logic                  defer, b_gnt;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_wdata, b_wdata;
  logic                  a_we, b_we;

  logic                  p1_v_q, p1_v_d;
  logic                  p2_v_q, p2_v_d;
  logic [IW-1:0]         p1_idx_q, p1_idx_d;
  logic [IW-1:0]         p2_idx_q, p2_idx_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]           cc_q, cc_d;

  // Rotated search: first requester is winner A, the next one is winner B
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[wrap(int'(rr_ptr_q) + k)]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = wrap(int'(rr_ptr_q) + k);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = wrap(int'(rr_ptr_q) + k);
        end
      end
    end
  end

  // Pair check: B waits when it touches A's word and either side writes
  always_comb begin
    a_addr  = req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
    b_addr  = req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
    a_wdata = req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
    b_wdata = req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];
    a_we    = req_we[a_idx];
    b_we    = req_we[b_idx];
    defer   = b_found && (a_addr == b_addr) && (a_we || b_we);
    b_gnt   = b_found && !defer;
  end

  // Grant and BRAM port drive, all forced low while in reset
  always_comb begin
    grant         = '0;
    readEnable_1  = 1'b0;
    writeEnable_1 = 1'b0;
    address_1     = '0;
    writeData_1   = '0;
    readEnable_2  = 1'b0;
    writeEnable_2 = 1'b0;
    address_2     = '0;
    writeData_2   = '0;
    if (reset && a_found) begin
      grant[a_idx]  = 1'b1;
      readEnable_1  = !a_we;
      writeEnable_1 = a_we;
      address_1     = a_addr;
      writeData_1   = a_wdata;
    end
    if (reset && b_gnt) begin
      grant[b_idx]  = 1'b1;
      readEnable_2  = !b_we;
      writeEnable_2 = b_we;
      address_2     = b_addr;
      writeData_2   = b_wdata;
    end
  end

  // Next pointer, read-return tracking and deferral counter
  always_comb begin
    last_idx = b_gnt ? b_idx : a_idx;
    rr_ptr_d = a_found ? wrap(int'(last_idx) + 1) : rr_ptr_q;
    p1_v_d   = a_found && !a_we;
    p1_idx_d = a_idx;
    p2_v_d   = b_gnt && !b_we;
    p2_idx_d = b_idx;
    cc_d     = cc_q;
    if (defer && (cc_q != 16'hFFFF)) begin
      cc_d = cc_q + 16'd1;
    end
  end

  // Read return: strobe owner and pass BRAM data, else hold last value
  always_comb begin
    rvalid  = '0;
    rdata_d = rdata_q;
    if (p1_v_q) begin
      rvalid[p1_idx_q] = 1'b1;
      rdata_d[p1_idx_q*DATA_WIDTH +: DATA_WIDTH] = readData_1;
    end
    if (p2_v_q) begin
      rvalid[p2_idx_q] = 1'b1;
      rdata_d[p2_idx_q*DATA_WIDTH +: DATA_WIDTH] = readData_2;
    end
    rdata          = rdata_d;
    conflict_count = cc_q;
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      p1_v_q   <= 1'b0;
      p2_v_q   <= 1'b0;
      p1_idx_q <= '0;
      p2_idx_q <= '0;
      rdata_q  <= '0;
      cc_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      p1_v_q   <= p1_v_d;
      p2_v_q   <= p2_v_d;
      p1_idx_q <= p1_idx_d;
      p2_idx_q <= p2_idx_d;
      rdata_q  <= rdata_d;
      cc_q     <= cc_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter.
// A dual-port BRAM model with one-cycle read latency sits behind the DUT.
module tb_bram_port_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   req_we = '0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   grant, rvalid;
  logic [127:0] rdata;
  logic         re1, we1, re2, we2;
  logic [7:0]   a1, a2;
  logic [31:0]  wd1, wd2;
  logic [31:0]  rd1, rd2;
  logic [15:0]  conflict_count;

  logic [31:0]  mem [256];
  int           n_vec = 0;
  int           n_err = 0;
  int           gcnt [4];
  logic [3:0]   exp_g;

  always #5 clock = ~clock;

  bram_port_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .readEnable_1(re1), .writeEnable_1(we1),
    .address_1(a1), .writeData_1(wd1), .readData_1(rd1),
    .readEnable_2(re2), .writeEnable_2(we2),
    .address_2(a2), .writeData_2(wd2), .readData_2(rd2),
    .conflict_count(conflict_count)
  );

  always @(posedge clock) begin
    if (re1) rd1 <= mem[a1];
    if (we1) mem[a1] <= wd1;
    if (re2) rd2 <= mem[a2];
    if (we2) mem[a2] <= wd2;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rq(input int i, input logic we,
                        input logic [7:0] ad, input logic [31:0] wd);
    req_we[i] = we;
    req_addr[i*8 +: 8] = ad;
    req_wdata[i*32 +: 32] = wd;
  endtask

  initial begin
    rd1 = '0;
    rd2 = '0;
    req = 4'b1111;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_re1", 32'(re1), 32'h0);
    chk("rst_addr1", 32'(a1), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_cc", 32'(conflict_count), 32'h0);
    chk("rst_rdata0", rdata[31:0], 32'h0);
    req = '0;
    step();
    reset = 1'b1;
    step();

    set_rq(0, 1'b1, 8'h10, 32'hA5A5_0001);
    set_rq(1, 1'b1, 8'h01, 32'h1111_0001);
    set_rq(2, 1'b1, 8'h02, 32'h2222_0002);
    req = 4'b0111;
    #1;
    chk("wr_grant", 32'(grant), 32'h3);
    chk("wr_we2", 32'(we2), 32'h1);
    step();
    chk("wr_norv", 32'(rvalid), 32'h0);
    req = 4'b0100;
    #1;
    chk("wr2_grant", 32'(grant), 32'h4);
    step();
    chk("wr2_norv", 32'(rvalid), 32'h0);
    req = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    set_rq(1, 1'b0, 8'h01, 32'h0);
    set_rq(2, 1'b0, 8'h02, 32'h0);
    req = 4'b0110;
    #1;
    chk("dual_grant", 32'(grant), 32'h6);
    chk("dual_a1", 32'(a1), 32'h01);
    chk("dual_a2", 32'(a2), 32'h02);
    chk("dual_re2", 32'(re2), 32'h1);
    step();
    req = '0;
    chk("dual_rvalid", 32'(rvalid), 32'h6);
    chk("dual_rd1", rdata[63:32], 32'h1111_0001);
    chk("dual_rd2", rdata[95:64], 32'h2222_0002);
    set_rq(0, 1'b0, 8'h10, 32'h0);
    set_rq(3, 1'b0, 8'h33, 32'h0);
    req = 4'b1111;
    #1;
    chk("rr3_grant", 32'(grant), 32'h9);
    req = '0;

    req = 4'b0001;
    #1;
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_re1", 32'(re1), 32'h1);
    chk("rd_a1", 32'(a1), 32'h10);
    step();
    req = '0;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_data", rdata[31:0], 32'hA5A5_0001);
    step();
    chk("hold_rvalid", 32'(rvalid), 32'h0);
    chk("hold_data", rdata[31:0], 32'hA5A5_0001);
    chk("hold_d1", rdata[63:32], 32'h1111_0001);

    req = 4'b1000;
    #1;
    chk("r3_grant", 32'(grant), 32'h8);
    step();
    req = '0;

    set_rq(0, 1'b1, 8'h20, 32'hDEAD_BEEF);
    set_rq(1, 1'b0, 8'h20, 32'h0);
    req = 4'b0011;
    #1;
    chk("cf_grant1", 32'(grant), 32'h1);
    chk("cf_we1", 32'(we1), 32'h1);
    chk("cf_re2", 32'(re2), 32'h0);
    step();
    chk("cf_cc", 32'(conflict_count), 32'h1);
    req = 4'b0010;
    #1;
    chk("cf_grant2", 32'(grant), 32'h2);
    step();
    req = '0;
    chk("cf_rvalid", 32'(rvalid), 32'h2);
    chk("cf_rdata", rdata[63:32], 32'hDEAD_BEEF);

    req = 4'b1000;
    step();
    for (int i = 0; i < 4; i++) begin
      set_rq(i, 1'b0, 8'(8'h30 + i), 32'h0);
      gcnt[i] = 0;
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      chk($sformatf("fair_g%0d", c), 32'(grant), 32'(exp_g));
      for (int i = 0; i < 4; i++) if (grant[i]) gcnt[i]++;
      step();
      chk($sformatf("fair_rv%0d", c), 32'(rvalid), 32'(exp_g));
    end
    req = '0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd4);

    set_rq(2, 1'b0, 8'h02, 32'h0);
    req = 4'b0100;
    #1;
    chk("mr_grant", 32'(grant), 32'h4);
    reset = 1'b0;
    #1;
    chk("mr_rst_grant", 32'(grant), 32'h0);
    chk("mr_rst_rv", 32'(rvalid), 32'h0);
    chk("mr_rst_cc", 32'(conflict_count), 32'h0);
    step();
    req = '0;
    chk("mr_rv_in", 32'(rvalid), 32'h0);
    reset = 1'b1;
    step();
    chk("mr_rv_out", 32'(rvalid), 32'h0);
    set_rq(0, 1'b1, 8'h50, 32'h0);
    set_rq(3, 1'b1, 8'h50, 32'h0);
    req = 4'b1001;
    #1;
    chk("mr_rrptr", 32'(grant), 32'h1);
    req = '0;

    set_rq(0, 1'b1, 8'h40, 32'h1);
    set_rq(1, 1'b1, 8'h40, 32'h2);
    req = 4'b0011;
    for (int c = 0; c < 65534; c++) @(posedge clock);
    #1;
    chk("sat_fffe", 32'(conflict_count), 32'hFFFE);
    for (int c = 0; c < 6; c++) @(posedge clock);
    #1;
    chk("sat_ffff", 32'(conflict_count), 32'hFFFF);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
